// File: rtl/pcm_vrom_if_pkg.sv
// Shared types and constants for the cartridge-side ADPCM V-ROM interface.
package pcm_pkg;

  localparam int PCM_AW = 24;
  localparam int PCM_DW = 8;
  localparam logic [PCM_DW-1:0] PCM_ERR_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_LO,
    ADDR_OK,
    FETCH,
    DRIVE
  } pcm_state_t;

endpackage

// File: rtl/pcm_vrom_if_if.sv
// Sound-bus and V-ROM pins seen by the PCM interface block.
// The master is the bus/ROM side; the slave is the block itself.
interface pcm_bus_if;
  import pcm_pkg::*;

  logic [PCM_DW-1:0] SDRAD_IN;
  logic [PCM_DW-1:0] SDRAD_OUT;
  logic              SDRAD_OE;
  logic [1:0]        SDRA_L;
  logic [3:0]        SDRA_U;
  logic              SDRMPX;
  logic              nSDROE;
  logic [PCM_AW-1:0] ROM_ADDR;
  logic              nROM_OE;
  logic [PCM_DW-1:0] ROM_DATA;

  modport master (
    output SDRAD_IN, SDRA_L, SDRA_U, SDRMPX, nSDROE, ROM_DATA,
    input  SDRAD_OUT, SDRAD_OE, ROM_ADDR, nROM_OE
  );

  modport slave (
    input  SDRAD_IN, SDRA_L, SDRA_U, SDRMPX, nSDROE, ROM_DATA,
    output SDRAD_OUT, SDRAD_OE, ROM_ADDR, nROM_OE
  );

endinterface

// File: rtl/pcm_vrom_if_edge_sync.sv
// Multi-flop synchroniser for one asynchronous strobe, with single-cycle
// rise/fall pulses taken from the synchronised level.
module pcm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // No reset here: the chain keeps tracking the pad through reset, so the
  // first cycle after reset release never reports a stale edge.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    sync_q <= sync_d;
    prev_q <= prev_d;
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/pcm_vrom_if.sv
// NEO-PCM2-style V-ROM interface: demuxes the ADPCM address, runs one ROM
// fetch per nSDROE strobe. Optional PCM_ADDR_AUTOINC_EN: post-read increment.
module pcm_vrom_if
  import pcm_pkg::*;
#(
  parameter int ROM_LAT     = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK_24M,
  input  logic        nRESET,
  pcm_bus_if.slave    bus,
  output logic        PROTO_ERR
);

  localparam logic [3:0] CNT_LAST = 4'(ROM_LAT - 1);

  logic mpx_rise, mpx_fall, oe_rise, oe_fall;

  pcm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mpx (
    .clk      (CLK_24M),
    .async_in (bus.SDRMPX),
    .rise     (mpx_rise),
    .fall     (mpx_fall)
  );

  pcm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_oe (
    .clk      (CLK_24M),
    .async_in (bus.nSDROE),
    .rise     (oe_rise),
    .fall     (oe_fall)
  );

  pcm_state_t        state_q, state_d, mpx_state;
  logic [PCM_AW-1:0] addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [PCM_DW-1:0] rd_data_q, rd_data_d;
  logic              rd_oe_q, rd_oe_d;
  logic              rom_oe_n_q, rom_oe_n_d;
  logic              err_q, err_d;
`ifdef PCM_ADDR_AUTOINC_EN
  logic              hit_q, hit_d;
`endif

  // The MPX edge is resolved first into mpx_state; the read strobe then acts
  // on that intermediate state, so a same-cycle address change reaches the ROM.
  always_comb begin
    state_d    = state_q;
    mpx_state  = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_oe_d    = rd_oe_q;
    rom_oe_n_d = rom_oe_n_q;
    err_d      = err_q;
`ifdef PCM_ADDR_AUTOINC_EN
    hit_d      = hit_q;
`endif

    if (mpx_rise || mpx_fall) begin
      if (state_q == FETCH || state_q == DRIVE) begin
        err_d = 1'b1;
      end else if (mpx_rise) begin
        addr_d[7:0]   = bus.SDRAD_IN;
        addr_d[9:8]   = bus.SDRA_L;
        addr_d[23:20] = bus.SDRA_U;
        mpx_state     = ADDR_LO;
      end else if (state_q == ADDR_LO) begin
        addr_d[17:10] = bus.SDRAD_IN;
        addr_d[19:18] = bus.SDRA_L;
        mpx_state     = ADDR_OK;
      end
    end

    state_d = mpx_state;

    case (mpx_state)
      IDLE, ADDR_LO: begin
        if (oe_fall) begin
          rd_data_d = PCM_ERR_BYTE;
          rd_oe_d   = 1'b1;
          err_d     = 1'b1;
          state_d   = DRIVE;
`ifdef PCM_ADDR_AUTOINC_EN
          hit_d     = 1'b0;
`endif
        end
      end
      ADDR_OK: begin
        if (oe_fall) begin
          rom_oe_n_d = 1'b0;
          cnt_d      = 4'd0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (oe_rise) begin
          rom_oe_n_d = 1'b1;
          state_d    = ADDR_OK;
        end else if (cnt_q == CNT_LAST) begin
          rd_data_d  = bus.ROM_DATA;
          rom_oe_n_d = 1'b1;
          rd_oe_d    = 1'b1;
          state_d    = DRIVE;
`ifdef PCM_ADDR_AUTOINC_EN
          hit_d      = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DRIVE: begin
        if (oe_rise) begin
          rd_oe_d = 1'b0;
          state_d = ADDR_OK;
`ifdef PCM_ADDR_AUTOINC_EN
          if (hit_q) addr_d = addr_q + 24'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= 4'd0;
      rd_data_q  <= 8'h00;
      rd_oe_q    <= 1'b0;
      rom_oe_n_q <= 1'b1;
      err_q      <= 1'b0;
`ifdef PCM_ADDR_AUTOINC_EN
      hit_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_oe_q    <= rd_oe_d;
      rom_oe_n_q <= rom_oe_n_d;
      err_q      <= err_d;
`ifdef PCM_ADDR_AUTOINC_EN
      hit_q      <= hit_d;
`endif
    end
  end

  assign bus.ROM_ADDR  = addr_q;
  assign bus.nROM_OE   = rom_oe_n_q;
  assign bus.SDRAD_OUT = rd_data_q;
  assign bus.SDRAD_OE  = rd_oe_q;
  assign PROTO_ERR     = err_q;

endmodule

// File: tb/tb_pcm_vrom_if.sv
// Directed bench for pcm_vrom_if: address demux table, read timing, abort,
// error reads, reset mid-transfer and (when defined) PCM_ADDR_AUTOINC_EN.
module tb_pcm_vrom_if;

  localparam int ROM_LAT     = 3;
  localparam int SYNC_STAGES = 2;
  localparam int RD_LAT      = 6;
  localparam int DROP_LAT    = 3;
`ifdef PCM_ADDR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef struct {
    logic [7:0]  lo_ad;
    logic [1:0]  lo_l;
    logic [3:0]  u;
    logic [7:0]  hi_ad;
    logic [1:0]  hi_l;
    logic [23:0] exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic n_reset;
  logic proto_err;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [23:0] cur_addr;
  logic [7:0]  last_data;

  pcm_bus_if bus();

  pcm_vrom_if #(.ROM_LAT(ROM_LAT), .SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK_24M   (clk),
    .nRESET    (n_reset),
    .bus       (bus),
    .PROTO_ERR (proto_err)
  );

  always #5 clk = ~clk;

  // Byte pattern of the V-ROM; 8'hEE on the bus whenever the ROM is disabled.
  function automatic logic [7:0] rom_model(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h2F;
  endfunction

  assign bus.ROM_DATA = bus.nROM_OE ? 8'hEE : rom_model(bus.ROM_ADDR);

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    n_reset    = 1'b0;
    bus.SDRMPX = 1'b0;
    bus.nSDROE = 1'b1;
    step(4);
    n_reset = 1'b1;
    step(1);
  endtask

  task automatic load_addr(input logic [7:0] lo_ad, input logic [1:0] lo_l, input logic [3:0] u,
                           input logic [7:0] hi_ad, input logic [1:0] hi_l);
    bus.SDRAD_IN = lo_ad;
    bus.SDRA_L   = lo_l;
    bus.SDRA_U   = u;
    bus.SDRMPX   = 1'b1;
    step(4);
    bus.SDRAD_IN = hi_ad;
    bus.SDRA_L   = hi_l;
    bus.SDRMPX   = 1'b0;
    step(4);
  endtask

  task automatic do_read(output int lat, output int low_cnt, output logic [23:0] addr_at_oe);
    lat        = -1;
    low_cnt    = 0;
    addr_at_oe = 24'hDEAD00;
    bus.nSDROE = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (!bus.nROM_OE) begin
        if (low_cnt == 0) addr_at_oe = bus.ROM_ADDR;
        low_cnt++;
      end
      if (bus.SDRAD_OE && lat < 0) lat = i;
    end
  endtask

  task automatic do_release(output int drop);
    drop       = -1;
    bus.nSDROE = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (!bus.SDRAD_OE && drop < 0) drop = i;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int          lat, low_cnt, drop;
    logic [23:0] a_oe, exp_after;
    exp_after = AUTOINC ? v.exp_addr + 24'd1 : v.exp_addr;
    load_addr(v.lo_ad, v.lo_l, v.u, v.hi_ad, v.hi_l);
    checkOutput("addr_capture", 32'(bus.ROM_ADDR), 32'(v.exp_addr));
    do_read(lat, low_cnt, a_oe);
    checkOutput("read_latency", lat, RD_LAT);
    checkOutput("rom_oe_width", low_cnt, ROM_LAT);
    checkOutput("rom_addr_at_oe", 32'(a_oe), 32'(v.exp_addr));
    checkOutput("read_data", 32'(bus.SDRAD_OUT), 32'(v.exp_data));
    checkOutput("proto_err_clean", 32'(proto_err), 32'h0);
    do_release(drop);
    checkOutput("oe_drop_latency", drop, DROP_LAT);
    checkOutput("addr_after_read", 32'(bus.ROM_ADDR), 32'(exp_after));
    cur_addr  = exp_after;
    last_data = v.exp_data;
  endtask

  initial begin
    vec_t        vecs[5];
    int          lat, low_cnt, drop, oe_seen;
    logic [23:0] a_oe;
    logic [23:0] exp_a;

    vecs[0] = '{8'h34, 2'b01, 4'hA, 8'h5C, 2'b10, 24'hA97134, 8'hC3};
    vecs[1] = '{8'h00, 2'b00, 4'h0, 8'h00, 2'b00, 24'h000000, 8'h2F};
    vecs[2] = '{8'hFF, 2'b11, 4'hF, 8'hFF, 2'b11, 24'hFFFFFF, 8'hD0};
    vecs[3] = '{8'h12, 2'b10, 4'h3, 8'hAB, 2'b01, 24'h36AE12, 8'hA5};
    vecs[4] = '{8'h80, 2'b11, 4'h5, 8'h01, 2'b00, 24'h500780, 8'hF8};

    n_reset      = 1'b0;
    bus.SDRAD_IN = 8'h00;
    bus.SDRA_L   = 2'b00;
    bus.SDRA_U   = 4'h0;
    bus.SDRMPX   = 1'b0;
    bus.nSDROE   = 1'b1;
    cur_addr     = 24'h0;
    last_data    = 8'h00;

    do_reset();
    checkOutput("reset_rom_addr", 32'(bus.ROM_ADDR), 32'h0);
    checkOutput("reset_nrom_oe", 32'(bus.nROM_OE), 32'h1);
    checkOutput("reset_sdrad_out", 32'(bus.SDRAD_OUT), 32'h0);
    checkOutput("reset_sdrad_oe", 32'(bus.SDRAD_OE), 32'h0);
    checkOutput("reset_proto_err", 32'(proto_err), 32'h0);

    // Read strobe with no address phase: error byte, no ROM access.
    do_read(lat, low_cnt, a_oe);
    checkOutput("err_read_latency", lat, SYNC_STAGES + 1);
    checkOutput("err_read_rom_oe", low_cnt, 0);
    checkOutput("err_read_data", 32'(bus.SDRAD_OUT), 32'hFF);
    checkOutput("err_read_proto", 32'(proto_err), 32'h1);
    do_release(drop);
    checkOutput("err_oe_drop", drop, DROP_LAT);
    checkOutput("err_sticky", 32'(proto_err), 32'h1);
    checkOutput("err_no_addr_inc", 32'(bus.ROM_ADDR), 32'h0);

    do_reset();
    checkOutput("reset_clears_err", 32'(proto_err), 32'h0);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Re-read with no new address phase.
    exp_a = cur_addr;
    do_read(lat, low_cnt, a_oe);
    checkOutput("reread_addr", 32'(a_oe), 32'(exp_a));
    checkOutput("reread_data", 32'(bus.SDRAD_OUT), AUTOINC ? 32'hF9 : 32'hF8);
    do_release(drop);
    cur_addr  = AUTOINC ? exp_a + 24'd1 : exp_a;
    last_data = bus.SDRAD_OUT;

    // Two reads starting at the top of the address space.
    load_addr(8'hFF, 2'b11, 4'hF, 8'hFF, 2'b11);
    do_read(lat, low_cnt, a_oe);
    checkOutput("wrap_read1_data", 32'(bus.SDRAD_OUT), 32'hD0);
    do_release(drop);
    do_read(lat, low_cnt, a_oe);
    checkOutput("wrap_read2_addr", 32'(a_oe), AUTOINC ? 32'h000000 : 32'hFFFFFF);
    checkOutput("wrap_read2_data", 32'(bus.SDRAD_OUT), AUTOINC ? 32'h2F : 32'hD0);
    do_release(drop);
    cur_addr  = AUTOINC ? 24'h000001 : 24'hFFFFFF;
    last_data = bus.SDRAD_OUT;

    // Strobe shorter than the ROM latency aborts the fetch.
    oe_seen    = 0;
    low_cnt    = 0;
    bus.nSDROE = 1'b0;
    step(1);
    bus.nSDROE = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus.SDRAD_OE) oe_seen = 1;
      if (!bus.nROM_OE) low_cnt++;
    end
    checkOutput("abort_no_oe", oe_seen, 0);
    checkOutput("abort_rom_oe_width", low_cnt, 1);
    checkOutput("abort_no_err", 32'(proto_err), 32'h0);
    checkOutput("abort_addr_kept", 32'(bus.ROM_ADDR), 32'(cur_addr));
    checkOutput("abort_data_kept", 32'(bus.SDRAD_OUT), 32'(last_data));

    // MPX fall and read strobe in the same cycle: new address is fetched.
    bus.SDRAD_IN = 8'h12;
    bus.SDRA_L   = 2'b10;
    bus.SDRA_U   = 4'h3;
    bus.SDRMPX   = 1'b1;
    step(4);
    bus.SDRAD_IN = 8'hAB;
    bus.SDRA_L   = 2'b01;
    bus.SDRMPX   = 1'b0;
    do_read(lat, low_cnt, a_oe);
    checkOutput("same_cycle_addr", 32'(a_oe), 32'h36AE12);
    checkOutput("same_cycle_latency", lat, RD_LAT);
    checkOutput("same_cycle_data", 32'(bus.SDRAD_OUT), 32'hA5);
    checkOutput("same_cycle_no_err", 32'(proto_err), 32'h0);
    do_release(drop);
    cur_addr = AUTOINC ? 24'h36AE13 : 24'h36AE12;

    // MPX rise while the fetch is in flight: flagged and ignored.
    bus.nSDROE = 1'b0;
    step(1);
    bus.SDRAD_IN = 8'h99;
    bus.SDRA_L   = 2'b11;
    bus.SDRA_U   = 4'h7;
    bus.SDRMPX   = 1'b1;
    step(11);
    checkOutput("mpx_in_fetch_err", 32'(proto_err), 32'h1);
    checkOutput("mpx_in_fetch_addr", 32'(bus.ROM_ADDR), 32'(cur_addr));
    checkOutput("mpx_in_fetch_data", 32'(bus.SDRAD_OUT), 32'(rom_model(cur_addr)));
    checkOutput("mpx_in_fetch_oe", 32'(bus.SDRAD_OE), 32'h1);

    // Reset while driving the bus; MPX stays high through reset.
    n_reset = 1'b0;
    step(1);
    checkOutput("rst_drive_sdrad_oe", 32'(bus.SDRAD_OE), 32'h0);
    checkOutput("rst_drive_nrom_oe", 32'(bus.nROM_OE), 32'h1);
    checkOutput("rst_drive_proto_err", 32'(proto_err), 32'h0);
    checkOutput("rst_drive_sdrad_out", 32'(bus.SDRAD_OUT), 32'h0);
    checkOutput("rst_drive_rom_addr", 32'(bus.ROM_ADDR), 32'h0);
    bus.nSDROE = 1'b1;
    step(3);
    n_reset = 1'b1;
    step(4);
    bus.SDRAD_IN = 8'h77;
    bus.SDRA_L   = 2'b11;
    bus.SDRMPX   = 1'b0;
    step(5);
    checkOutput("lone_mpx_fall_addr", 32'(bus.ROM_ADDR), 32'h0);
    checkOutput("lone_mpx_fall_err", 32'(proto_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
